// File: rtl/z80_bus_sequencer.sv
// rtl/z80_bus_sequencer.sv - registered T-state bus sequencer with fixed-priority arbitration
module z80_bus_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic        i_rd_req,
    input  logic        i_in_req,
    input  logic        i_wr_req,
    input  logic        i_out_req,
    input  logic [15:0] i_if_addr,
    input  logic [15:0] i_rd_addr,
    input  logic [15:0] i_in_addr,
    input  logic [15:0] i_wr_addr,
    input  logic [15:0] i_out_addr,
    input  logic [7:0]  i_wr_data,
    input  logic [7:0]  i_out_data,
    output logic        o_if_ack,
    output logic        o_rd_ack,
    output logic        o_in_ack,
    output logic        o_wr_ack,
    output logic        o_out_ack,
    output logic [7:0]  o_rdata,
    output logic        o_bus_err,
    output logic        o_busy,
    input  logic [7:0]  i_data_input,
    input  logic        i_wait_n,
    output logic [15:0] o_address,
    output logic        o_m1,
    output logic        o_mreq,
    output logic        o_iorq,
    output logic        o_rd,
    output logic        o_wr,
    output logic [7:0]  o_data_output,
    output logic        o_data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TWA,
        ST_TW,
        ST_T3
    } state_t;

    // requester indices; also the bit positions of the ack vector
    localparam logic [2:0] SEL_IF  = 3'd0;
    localparam logic [2:0] SEL_RD  = 3'd1;
    localparam logic [2:0] SEL_IN  = 3'd2;
    localparam logic [2:0] SEL_WR  = 3'd3;
    localparam logic [2:0] SEL_OUT = 3'd4;

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic [4:0]  r_ack;
    logic        r_bus_err;
    logic        r_busy;
    logic [7:0]  r_rdata;
    logic [15:0] r_address;
    logic        r_m1;
    logic        r_mreq;
    logic        r_iorq;
    logic        r_rd;
    logic        r_wr;
    logic [7:0]  r_data_output;
    logic        r_data_oe;

    logic [4:0]  w_req;
    logic        w_gnt;
    logic [2:0]  w_gnt_sel;
    logic [15:0] w_gnt_addr;
    logic [7:0]  w_gnt_data;
    logic        w_gnt_wr;
    logic        w_is_io;
    logic        w_is_wr;

    // a requester whose ack is showing this cycle is excluded from arbitration
    assign w_req = {i_out_req, i_wr_req, i_in_req, i_rd_req, i_if_req} & ~r_ack;

    assign w_is_io  = (r_sel == SEL_IN) || (r_sel == SEL_OUT);
    assign w_is_wr  = (r_sel == SEL_WR) || (r_sel == SEL_OUT);
    assign w_gnt_wr = (w_gnt_sel == SEL_WR) || (w_gnt_sel == SEL_OUT);

    // fixed-priority grant: wr > out > rd > in > if
    always_comb begin
        w_gnt      = 1'b1;
        w_gnt_sel  = SEL_IF;
        w_gnt_addr = i_if_addr;
        w_gnt_data = 8'h00;
        if (w_req[SEL_WR]) begin
            w_gnt_sel  = SEL_WR;
            w_gnt_addr = i_wr_addr;
            w_gnt_data = i_wr_data;
        end else if (w_req[SEL_OUT]) begin
            w_gnt_sel  = SEL_OUT;
            w_gnt_addr = i_out_addr;
            w_gnt_data = i_out_data;
        end else if (w_req[SEL_RD]) begin
            w_gnt_sel  = SEL_RD;
            w_gnt_addr = i_rd_addr;
        end else if (w_req[SEL_IN]) begin
            w_gnt_sel  = SEL_IN;
            w_gnt_addr = i_in_addr;
        end else if (!w_req[SEL_IF]) begin
            w_gnt      = 1'b0;
            w_gnt_addr = 16'h0000;
        end
    end

    // bus cycle state machine; every bus output is registered for the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_sel         <= SEL_IF;
            r_wait_cnt    <= 8'd0;
            r_timeout     <= 1'b0;
            r_ack         <= 5'b0;
            r_bus_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_rdata       <= 8'h00;
            r_address     <= 16'h0000;
            r_m1          <= 1'b1;
            r_mreq        <= 1'b1;
            r_iorq        <= 1'b1;
            r_rd          <= 1'b1;
            r_wr          <= 1'b1;
            r_data_output <= 8'h00;
            r_data_oe     <= 1'b0;
        end else begin
            r_ack     <= 5'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_state       <= ST_T1;
                        r_sel         <= w_gnt_sel;
                        r_address     <= w_gnt_addr;
                        r_data_output <= w_gnt_data;
                        r_data_oe     <= w_gnt_wr;
                        r_m1          <= (w_gnt_sel != SEL_IF);
                        r_busy        <= 1'b1;
                        r_wait_cnt    <= 8'd0;
                        r_timeout     <= 1'b0;
                    end
                end
                ST_T1: begin
                    r_state <= ST_T2;
                    r_mreq  <= w_is_io;
                    r_iorq  <= !w_is_io;
                    r_rd    <= w_is_wr;
                    r_wr    <= !w_is_wr;
                end
                ST_T2: begin
                    if (w_is_io)       r_state <= ST_TWA;
                    else if (!i_wait_n) r_state <= ST_TW;
                    else               r_state <= ST_T3;
                end
                ST_TWA: begin
                    r_state <= i_wait_n ? ST_T3 : ST_TW;
                end
                ST_TW: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (!i_wait_n && (r_wait_cnt < 8'(MAX_WAIT))) begin
                        r_state <= ST_TW;
                    end else begin
                        r_state   <= ST_T3;
                        r_timeout <= !i_wait_n;
                    end
                end
                ST_T3: begin
                    r_state       <= ST_IDLE;
                    r_ack         <= 5'd1 << r_sel;
                    r_bus_err     <= r_timeout;
                    if (!w_is_wr) r_rdata <= r_timeout ? 8'hFF : i_data_input;
                    r_busy        <= 1'b0;
                    r_address     <= 16'h0000;
                    r_m1          <= 1'b1;
                    r_mreq        <= 1'b1;
                    r_iorq        <= 1'b1;
                    r_rd          <= 1'b1;
                    r_wr          <= 1'b1;
                    r_data_oe     <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_if_ack      = r_ack[SEL_IF];
    assign o_rd_ack      = r_ack[SEL_RD];
    assign o_in_ack      = r_ack[SEL_IN];
    assign o_wr_ack      = r_ack[SEL_WR];
    assign o_out_ack     = r_ack[SEL_OUT];
    assign o_rdata       = r_rdata;
    assign o_bus_err     = r_bus_err;
    assign o_busy        = r_busy;
    assign o_address     = r_address;
    assign o_m1          = r_m1;
    assign o_mreq        = r_mreq;
    assign o_iorq        = r_iorq;
    assign o_rd          = r_rd;
    assign o_wr          = r_wr;
    assign o_data_output = r_data_output;
    assign o_data_oe     = r_data_oe;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// tb/tb_z80_bus_sequencer.sv - randomized self-checking bench with a cycle-schedule reference model
module tb_z80_bus_sequencer;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req;
    logic [15:0] addr_of [5];
    logic [7:0]  wdat_of [5];
    logic [7:0]  data_input;
    logic        wait_n;

    logic        if_ack, rd_ack, in_ack, wr_ack, out_ack;
    logic [7:0]  rdata;
    logic        bus_err, busy;
    logic [15:0] address;
    logic        m1, mreq, iorq, rd, wr;
    logic [7:0]  data_output;
    logic        data_oe;
    logic [4:0]  ack;
    logic [4:0]  strb;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_rdata;

    always #5 clk = ~clk;

    assign ack  = {out_ack, wr_ack, in_ack, rd_ack, if_ack};
    assign strb = {m1, mreq, iorq, rd, wr};

    z80_bus_sequencer #(.MAX_WAIT(MAXW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_if_req      (req[0]),
        .i_rd_req      (req[1]),
        .i_in_req      (req[2]),
        .i_wr_req      (req[3]),
        .i_out_req     (req[4]),
        .i_if_addr     (addr_of[0]),
        .i_rd_addr     (addr_of[1]),
        .i_in_addr     (addr_of[2]),
        .i_wr_addr     (addr_of[3]),
        .i_out_addr    (addr_of[4]),
        .i_wr_data     (wdat_of[3]),
        .i_out_data    (wdat_of[4]),
        .o_if_ack      (if_ack),
        .o_rd_ack      (rd_ack),
        .o_in_ack      (in_ack),
        .o_wr_ack      (wr_ack),
        .o_out_ack     (out_ack),
        .o_rdata       (rdata),
        .o_bus_err     (bus_err),
        .o_busy        (busy),
        .i_data_input  (data_input),
        .i_wait_n      (wait_n),
        .o_address     (address),
        .o_m1          (m1),
        .o_mreq        (mreq),
        .o_iorq        (iorq),
        .o_rd          (rd),
        .o_wr          (wr),
        .o_data_output (data_output),
        .o_data_oe     (data_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the requesters in 'set' at relative cycle 0 with the bus idle.  The model
    // lays out the whole schedule: winners in priority order, each cycle taking
    // 4 (memory) or 5 (IO) clocks plus its wait states, with one IDLE/ack clock between.
    // nw < 0 picks a random wait count per cycle; nw > MAXW holds wait_n low to timeout.
    task automatic do_batch(input logic [4:0] set, input int nw, input int din_fix);
        logic [4:0]  e_ack  [128];
        logic        e_err  [128];
        logic        e_busy [128];
        logic        e_oe   [128];
        logic        e_wl   [128];
        logic [15:0] e_addr [128];
        logic [4:0]  e_strb [128];
        logic [7:0]  e_dout [128];
        int          e_rd   [128];
        logic [7:0]  din_hist [128];
        int          prio [5] = '{3, 4, 1, 2, 0};
        int          s, w, len, ack_c, first, idx, nlow;
        logic        io, wrt, to;
        for (int k = 0; k < 128; k++) begin
            e_ack[k] = 5'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0; e_oe[k] = 1'b0;
            e_wl[k] = 1'b0; e_addr[k] = 16'h0000; e_strb[k] = 5'b11111;
            e_dout[k] = 8'h00; e_rd[k] = 0; din_hist[k] = 8'h00;
        end
        s = 1;
        for (int p = 0; p < 5; p++) begin
            idx = prio[p];
            if (set[idx]) begin
                io    = (idx == 2) || (idx == 4);
                wrt   = (idx == 3) || (idx == 4);
                w     = (nw < 0) ? int'($urandom_range(0, MAXW)) : nw;
                to    = (w > MAXW);
                len   = (io ? 5 : 4) + (to ? MAXW + 1 : w);
                ack_c = s + len - 1;
                for (int k = s; k < ack_c; k++) begin
                    e_busy[k] = 1'b1;
                    e_addr[k] = addr_of[idx];
                    e_oe[k]   = wrt;
                    e_dout[k] = wdat_of[idx];
                    if (k == s) e_strb[k] = {(idx != 0), 4'b1111};
                    else        e_strb[k] = {(idx != 0), io, !io, wrt, !wrt};
                end
                first = io ? s + 2 : s + 1;
                nlow  = to ? MAXW + 2 : w;
                for (int k = 0; k < nlow; k++) e_wl[first + k] = 1'b1;
                e_ack[ack_c][idx] = 1'b1;
                e_err[ack_c]      = to;
                e_rd[ack_c]       = wrt ? 0 : (to ? 2 : 1);
                s = ack_c + 1;
            end
        end
        for (int k = 0; k <= s + 1; k++) begin
            if (k == 0) req = req | set;
            if (k > 0 && e_rd[k] == 1) m_rdata = din_hist[k-1];
            if (e_rd[k] == 2)          m_rdata = 8'hFF;
            check($sformatf("ack@%0d", k),   32'(ack),     32'(e_ack[k]));
            check($sformatf("err@%0d", k),   32'(bus_err), 32'(e_err[k]));
            check($sformatf("busy@%0d", k),  32'(busy),    32'(e_busy[k]));
            check($sformatf("addr@%0d", k),  32'(address), 32'(e_addr[k]));
            check($sformatf("strb@%0d", k),  32'(strb),    32'(e_strb[k]));
            check($sformatf("oe@%0d", k),    32'(data_oe), 32'(e_oe[k]));
            check($sformatf("rdata@%0d", k), 32'(rdata),   32'(m_rdata));
            if (e_oe[k]) check($sformatf("dout@%0d", k), 32'(data_output), 32'(e_dout[k]));
            req        = req & ~ack;
            wait_n     = !e_wl[k];
            data_input = (din_fix < 0) ? 8'($urandom) : 8'(din_fix);
            din_hist[k] = data_input;
            tick();
        end
        req    = 5'b0;
        wait_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 5'b0;
        wait_n     = 1'b1;
        data_input = 8'h00;
        m_rdata    = 8'h00;
        for (int i = 0; i < 5; i++) begin
            addr_of[i] = 16'h0000;
            wdat_of[i] = 8'h00;
        end
        tick();
        tick();
        check("rst_addr",  32'(address),     32'h0000);
        check("rst_strb",  32'(strb),        32'h1f);
        check("rst_ack",   32'(ack),         32'h0);
        check("rst_oe",    32'(data_oe),     32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_err",   32'(bus_err),     32'h0);
        check("rst_rdata", 32'(rdata),       32'h00);
        check("rst_dout",  32'(data_output), 32'h00);
        rst_n = 1'b1;
        tick();

        // fetch
        addr_of[0] = 16'h1234;
        do_batch(5'b00001, 0, 8'h3E);
        check("fetch_rdata", 32'(rdata), 32'h3E);

        // write beats read, then read is served
        addr_of[3] = 16'h8000; wdat_of[3] = 8'h5A; addr_of[1] = 16'h8001;
        do_batch(5'b01010, 0, -1);

        // IO output with automatic wait
        addr_of[4] = 16'h00FE; wdat_of[4] = 8'h07;
        do_batch(5'b10000, 0, -1);

        // memory read with three wait states
        addr_of[1] = 16'h4321;
        do_batch(5'b00010, 3, -1);

        // IO input timeout, then a normal IO input
        addr_of[2] = 16'h0011;
        do_batch(5'b00100, 99, -1);
        check("timeout_rdata", 32'(rdata), 32'hFF);
        do_batch(5'b00100, 0, -1);

        // reset during TW of a write
        addr_of[3] = 16'hC0DE; wdat_of[3] = 8'hA5;
        wait_n = 1'b0;
        req[3] = 1'b1;
        tick();
        tick();
        tick();
        check("mid_wr_active", 32'(wr), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_strb", 32'(strb),    32'h1f);
        check("mid_rst_oe",   32'(data_oe), 32'h0);
        check("mid_rst_busy", 32'(busy),    32'h0);
        check("mid_rst_addr", 32'(address), 32'h0000);
        tick();
        check("mid_rst_ack",  32'(ack),     32'h0);
        m_rdata = 8'h00;
        check("mid_rst_rdata", 32'(rdata),  32'h00);
        rst_n  = 1'b1;
        wait_n = 1'b1;
        do_batch(5'b01000, 0, -1);

        // randomized mixes of simultaneous requests and wait states
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 5; i++) begin
                addr_of[i] = 16'($urandom);
                wdat_of[i] = 8'($urandom);
            end
            do_batch(5'($urandom_range(1, 31)), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_bus_sequencer.md
# z80_bus_sequencer

Sequences the Z80 core's external bus between its five internal bus requesters: instruction fetch, memory read, IO input, memory write and IO output. Runs T-state style bus cycles with fixed-priority arbitration, wait-state insertion and a wait timeout. All bus strobes are registered, so the combinational strobe decode in the CPU top is replaced by a clean, glitch-free bus interface.

## Interface
- `MAX_WAIT`, default 15: maximum wait states allowed per cycle before timeout (1..255).
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req`/`rd_req`/`in_req`/`wr_req`/`out_req` in 1 each: level requests for fetch, memory read, IO input, memory write and IO output.
- `if_addr`/`rd_addr`/`in_addr`/`wr_addr`/`out_addr` in 16 each: per-requester address.
- `wr_data`/`out_data` in 8 each: write data for memory write and IO output.
- `if_ack`/`rd_ack`/`in_ack`/`wr_ack`/`out_ack` out 1 each: one-cycle completion pulses.
- `rdata` out 8: read data from the last completed read, fetch or IO input.
- `bus_err` out 1: pulses with the ack of a cycle that timed out.
- `busy` out 1: high in every state except IDLE.
- `data_input` in 8: external data bus, input side.
- `wait_n` in 1: external wait request, active low.
- `address` out 16: external address.
- `m1`, `mreq`, `iorq`, `rd`, `wr` out 1 each: active-low bus strobes.
- `data_output` out 8: external write data.
- `data_oe` out 1: high while the core drives the data bus.

## Operation
- **Arbitration** happens only in IDLE. Fixed priority, highest first: wr > out > rd > in > if.
  - On grant, the sequencer latches the requester index, its address and its write data, then moves to T1.
- **States:** IDLE, T1, T2, TWA, TW, T3.
- **Transitions:**
  - IDLE → T1 when any unmasked request is high.
  - T1 → T2.
  - T2 → TWA for IO cycles.
  - T2 → TW for memory cycles if `wait_n`=0.
  - T2 → T3 for memory cycles if `wait_n`=1.
  - TWA → TW if `wait_n`=0, else → T3.
  - TW → TW while `wait_n`=0 and the wait count is below `MAX_WAIT`, else → T3.
  - T3 → IDLE, always.
- **Strobes per state:**
  - T1: address valid; `m1`=0 for fetch; `mreq`, `iorq`, `rd` and `wr` all 1.
  - T2, TWA, TW, T3: `mreq`=0 for memory or fetch, `iorq`=0 for IO; `rd`=0 for reads, `wr`=0 for writes.
  - `m1` stays 0 from T1 through T3 for fetch only.
  - Writes: `data_output` holds the latched data and `data_oe`=1 from T1 through T3.
- **Wait counter:**
  - 8 bits; cleared in T1; incremented each cycle spent in TW.
  - Reaching `MAX_WAIT` forces TW → T3 and sets the timeout flag.
- **Completion:**
  - At the edge ending T3, reads capture `rdata` ← `data_input`.
  - A timed-out read captures 8'hFF instead.
  - The granted requester's ack goes high for the following IDLE cycle; `bus_err` pulses in that same cycle if the cycle timed out.
  - Non-read cycles leave `rdata` unchanged.
- **Ack masking:** in the IDLE cycle where an ack is high, that requester is excluded from arbitration.
- **Requester rules:**
  - Hold req, addr and data stable until ack is sampled high.
  - Drop req on that same edge.
  - A request dropped before ack is illegal; the sequencer still completes the latched cycle.
- **Simultaneous requests:** the loser is served in a later arbitration. There is no fairness; starvation of low-priority requesters is accepted by design.

## Timing
- **Reset values:**
  - `address`=16'h0000, `data_output`=8'h00, `rdata`=8'h00.
  - `m1`=`mreq`=`iorq`=`rd`=`wr`=1.
  - All acks 0; `data_oe`=0, `bus_err`=0, `busy`=0; state IDLE.
- **Reset mid-cycle:** the async return to these values takes effect immediately; the aborted cycle is never acked.
- **Latency:** req high in IDLE at cycle 0 → ack in cycle 4 for a memory cycle with no waits.
  - IO cycles take 5 cycles.
  - Each extra TW adds 1 cycle.
  - A timeout gives 5 + `MAX_WAIT` for memory and 6 + `MAX_WAIT` for IO.
- **Back-to-back:** the ack/IDLE cycle is always inserted. Peak throughput is one memory cycle per 4 clocks.
- **Sampling points:**
  - `wait_n` is sampled only at edges ending T2 (memory), TWA and TW.
  - `data_input` is sampled only at the edge ending T3.
- **IDLE drive:** `address` returns to 16'h0000 in IDLE.

## Test plan
- **Fetch:** `if_req`=1, `if_addr`=16'h1234, `data_input`=8'h3E, `wait_n`=1 → T1 shows `address`=1234 and `m1`=0; T2–T3 show `mreq`=`rd`=0; `if_ack` at cycle 4; `rdata`=8'h3E; `bus_err`=0.
- **Priority and masking:** `wr_req` (addr 8000, data 5A) and `rd_req` (addr 8001) rise together → write served first with `wr`=0, `data_output`=5A, `data_oe`=1; `wr_ack` at cycle 4; read T1 at cycle 5; `rd_ack` at cycle 8.
- **IO output:** `out_req`, `out_addr`=16'h00FE, `out_data`=8'h07 → `iorq`=0 and `wr`=0 through T2–T3 with the auto TWA; `out_ack` at cycle 5; `mreq` stays 1.
- **Wait insertion:** memory read with `wait_n`=0 for 3 sampled edges → 3 TW states; ack at cycle 7; `rdata` is the value present at the end of T3.
- **Timeout:** `MAX_WAIT`=4, `in_req` with `wait_n` held 0 → ack at cycle 10; `rdata`=8'hFF; `bus_err`=1 for one cycle; the next request proceeds normally.
- **Reset mid-cycle:** assert `reset`=0 during TW of a write → strobes go to 1 and `data_oe` to 0 immediately; no ack. After release with the request still high, a fresh cycle starts from T1.
